key_search_scheduler: RTL and testbench
=======================================

Name: key_search_scheduler

Overview:
- Sequences the RC4 key-space search across NUM_CORES parallel decryption cores.
- Hands each idle core the next candidate key in ascending order and collects per-core pass/fail results.
- Stops all cores on the first hit; reports exhaustion if no key in 0..KEY_MAX decrypts.
- Sits between the ROM reader (start is gated by ROM-read-done at top level) and the decryption core array.

Parameters:
- NUM_CORES, 4: number of decryption cores scheduled (1..16).
- KEY_WIDTH, 24: width of secret_key fed to each core.
- KEY_MAX, 24'h3FFFFF: last candidate key, inclusive; upper bits above it are always 0.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a search; sampled only in IDLE, FOUND or EXHAUSTED.
- core_start  out  NUM_CORES  one-cycle pulse per core; the matching core_key slice is valid in the same cycle.
- core_key  out  NUM_CORES*KEY_WIDTH  key for core i in bits [i*KEY_WIDTH +: KEY_WIDTH]; held until that core's next start.
- core_done  in  NUM_CORES  one-cycle pulse from core i, meaning its decryption finished.
- core_found  in  NUM_CORES  qualified by core_done[i]; 1 = plaintext valid.
- core_abort  out  1  one-cycle pulse telling all cores to return to idle.
- busy  out  1  high in RUN.
- found  out  1  sticky; high in FOUND.
- exhausted  out  1  sticky; high in EXHAUSTED.
- found_key  out  KEY_WIDTH  winning key, valid while found=1.

Behaviour:
- Reset (reset=0 at clk edge):
  - State goes to IDLE.
  - core_start, core_abort, busy, found, exhausted all go to 0; found_key and every core_key slice go to 0.
  - next_key goes to 0; all per-core in-flight flags are cleared.
  - Reset mid-run drops everything; cores are not aborted explicitly, because they share the same reset.
- States: IDLE, RUN, FOUND, EXHAUSTED.
- IDLE, FOUND or EXHAUSTED with start=1:
  - Go to RUN; next_key=0; in-flight flags cleared; found and exhausted cleared.
  - found_key keeps its last value until the next hit.
- RUN, dispatch:
  - Each cycle, if some core is not in flight and next_key<=KEY_MAX, the lowest-indexed such core i is dispatched.
  - Dispatch means: core_start[i]=1 in the next cycle (registered), core_key slice i=next_key, in-flight[i] set, next_key incremented.
  - At most one dispatch per cycle.
  - The first core_start[0] with key 0 appears one cycle after start is sampled.
- RUN, completion:
  - core_done[i] with in-flight[i]=1 clears in-flight[i].
  - The core becomes eligible again in the same cycle, so its redispatch pulse appears on the following cycle.
  - core_done on a core that is not in flight is ignored.
- RUN, hit:
  - Any qualified core_done[i] with core_found[i]=1 moves the state to FOUND.
  - found_key takes core_key slice i; if several cores hit in the same cycle, the lowest index wins.
  - core_abort pulses for one cycle and all in-flight flags are cleared.
  - A dispatch computed in that same cycle is suppressed: no core_start is issued.
- RUN, exhaustion:
  - When next_key > KEY_MAX and no core is in flight, move to EXHAUSTED with exhausted=1.
  - A hit in the final completion cycle takes priority over exhaustion.
- next_key width is KEY_WIDTH+1, so incrementing past KEY_MAX=all-ones does not wrap.
- Each key in 0..KEY_MAX is dispatched exactly once per search, in ascending order.
- start while in RUN is ignored.

Optional Feature:
- Macro: KEY_SEARCH_PROGRESS_EN.
- When defined, two extra outputs are present:
  - keys_tried (KEY_WIDTH+1): counts qualified core_done pulses since the last start; cleared on reset and on start; frozen in FOUND and EXHAUSTED.
  - progress_leds (10): keys_tried[KEY_WIDTH-1 -: 10], for LEDR.
- When not defined, neither port nor the counter exists, and behaviour is otherwise identical.

Test Plan:
1. Hold reset=0 for 3 cycles with start=1 and core_done pulsing -> all outputs 0, no core_start pulses; after release, state is IDLE.
2. NUM_CORES=4, KEY_MAX=15; cores reply done with found=0 three cycles after each start -> exactly 16 core_start pulses carrying keys 0..15, each once and in order; exhausted=1, found=0, busy=0.
3. Same setup, but the core holding key 9 replies found=1 -> found=1, found_key=9, one core_abort pulse, no core_start afterwards, exhausted stays 0.
4. Cores 1 and 2 report found=1 in the same cycle, holding keys 5 and 6 -> found_key=5.
5. reset=0 asserted mid-run at key 7, then released and start pulsed -> the next core_start[0] carries key 0; found and exhausted are 0.
6. start pulsed during RUN -> no restart and no repeated key; start pulsed in EXHAUSTED -> a new search from key 0. With KEY_SEARCH_PROGRESS_EN defined, keys_tried=16 at exhaustion in scenario 2.

Source files
------------

// File: rtl/key_search_scheduler.sv
// rtl/key_search_scheduler.sv - RC4 key-space search scheduler over NUM_CORES decryption cores
// Optional progress counter and LED outputs are enabled by defining KEY_SEARCH_PROGRESS_EN.
module key_search_scheduler #(
  parameter int                   NUM_CORES = 4,
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = 24'h3FFFFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic [NUM_CORES-1:0]           core_start,
  output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  input  logic [NUM_CORES-1:0]           core_done,
  input  logic [NUM_CORES-1:0]           core_found,
  output logic                           core_abort,
  output logic                           busy,
  output logic                           found,
  output logic                           exhausted,
  output logic [KEY_WIDTH-1:0]           found_key
`ifdef KEY_SEARCH_PROGRESS_EN
  ,
  output logic [KEY_WIDTH:0]             keys_tried,
  output logic [9:0]                     progress_leds
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FOUND, S_EXHAUSTED} state_t;

  // One extra bit so stepping past an all-ones KEY_MAX cannot wrap back to 0.
  localparam logic [KEY_WIDTH:0] KEY_LIMIT = {1'b0, KEY_MAX};

  state_t                 state;
  logic [KEY_WIDTH:0]     next_key;
  logic [NUM_CORES-1:0]   inflight;

  logic [NUM_CORES-1:0]   done_q;
  logic [NUM_CORES-1:0]   hit_vec;
  logic [NUM_CORES-1:0]   inflight_after;
  logic [NUM_CORES-1:0]   disp_vec;
  logic [KEY_WIDTH-1:0]   hit_key;
  logic                   keys_left;

  // Scanning from the top down lets the lowest index win both the hit and the dispatch.
  always_comb begin
    done_q         = core_done & inflight;
    hit_vec        = done_q & core_found;
    inflight_after = inflight & ~done_q;
    hit_key        = '0;
    disp_vec       = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
      if (!inflight_after[i]) begin
        disp_vec    = '0;
        disp_vec[i] = 1'b1;
      end
    end
    keys_left = (next_key <= KEY_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      next_key   <= '0;
      inflight   <= '0;
      core_start <= '0;
      core_key   <= '0;
      core_abort <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      found_key  <= '0;
`ifdef KEY_SEARCH_PROGRESS_EN
      keys_tried <= '0;
`endif
    end else begin
      core_start <= '0;
      core_abort <= 1'b0;
      case (state)
        S_RUN: begin
`ifdef KEY_SEARCH_PROGRESS_EN
          keys_tried <= keys_tried + (KEY_WIDTH+1)'($countones(done_q));
`endif
          if (|hit_vec) begin
            state      <= S_FOUND;
            found      <= 1'b1;
            found_key  <= hit_key;
            core_abort <= 1'b1;
            busy       <= 1'b0;
            inflight   <= '0;
          end else if (!keys_left && inflight_after == '0) begin
            state     <= S_EXHAUSTED;
            exhausted <= 1'b1;
            busy      <= 1'b0;
            inflight  <= '0;
          end else if (keys_left && |disp_vec) begin
            inflight   <= inflight_after | disp_vec;
            core_start <= disp_vec;
            next_key   <= next_key + 1'b1;
            for (int i = 0; i < NUM_CORES; i++) begin
              if (disp_vec[i]) begin
                core_key[i*KEY_WIDTH +: KEY_WIDTH] <= next_key[KEY_WIDTH-1:0];
              end
            end
          end else begin
            inflight <= inflight_after;
          end
        end
        default: begin
          if (start) begin
            state     <= S_RUN;
            next_key  <= '0;
            inflight  <= '0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            busy      <= 1'b1;
`ifdef KEY_SEARCH_PROGRESS_EN
            keys_tried <= '0;
`endif
          end
        end
      endcase
    end
  end

`ifdef KEY_SEARCH_PROGRESS_EN
  assign progress_leds = keys_tried[KEY_WIDTH-1 -: 10];
`endif

endmodule

// File: tb/tb_key_search_scheduler.sv
// tb/tb_key_search_scheduler.sv - directed bench for key_search_scheduler with a small core-array model
module tb_key_search_scheduler;
  localparam int NC = 4;
  localparam int KW = 24;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b1;
  logic [NC-1:0]     core_start;
  logic [NC*KW-1:0]  core_key;
  logic [NC-1:0]     core_done = '0;
  logic [NC-1:0]     core_found = '0;
  logic              core_abort, busy, found, exhausted;
  logic [KW-1:0]     found_key;
`ifdef KEY_SEARCH_PROGRESS_EN
  logic [KW:0]       keys_tried;
  logic [9:0]        progress_leds;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int keys_q[$];
  int core_q[$];
  int cnt[NC];
  int ckey[NC];
  int hit_a = -1;
  int hit_b = -1;
  int slow_key = -1;
  int abort_cnt = 0;
  int late_starts = 0;

  key_search_scheduler #(.NUM_CORES(NC), .KEY_WIDTH(KW), .KEY_MAX(24'd15)) dut (
    .clk(clk), .reset(reset), .start(start),
    .core_start(core_start), .core_key(core_key),
    .core_done(core_done), .core_found(core_found),
    .core_abort(core_abort), .busy(busy), .found(found),
    .exhausted(exhausted), .found_key(found_key)
`ifdef KEY_SEARCH_PROGRESS_EN
    , .keys_tried(keys_tried), .progress_leds(progress_leds)
`endif
  );

  always #5 clk = ~clk;

  // Core array model: done three cycles after start (four for slow_key).
  always @(negedge clk) begin
    if (!reset) begin
      core_done  = ~core_done;
      core_found = '1;
      for (int i = 0; i < NC; i++) cnt[i] = 0;
    end else begin
      core_done  = '0;
      core_found = '0;
      if (core_abort) begin
        abort_cnt++;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
      end
      for (int i = 0; i < NC; i++) begin
        if (core_start[i]) begin
          ckey[i] = int'(core_key[i*KW +: KW]);
          keys_q.push_back(ckey[i]);
          core_q.push_back(i);
          if (found || exhausted) late_starts++;
          cnt[i] = (ckey[i] == slow_key) ? 4 : 3;
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            core_done[i]  = 1'b1;
            core_found[i] = (ckey[i] == hit_a) || (ckey[i] == hit_b);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (!(found || exhausted) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", 64'(found || exhausted), 64'd1);
  endtask

  task automatic wait_keys(input int want, input int budget);
    int n = 0;
    while (keys_q.size() < want && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("keys_reached", 64'(keys_q.size() >= want), 64'd1);
  endtask

  task automatic check_order(input string tag);
    int bad = 0;
    for (int i = 0; i < keys_q.size(); i++) if (keys_q[i] != i) bad++;
    check(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    int k;
    // Reset held with start high and core_done toggling
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("reset_outs", {core_start, core_abort, busy, found, exhausted,
                           1'(found_key != 0), 1'(core_key != 0)}, 64'd0);
    end
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle_after_reset", {core_start, busy}, 64'd0);

    // Full exhaustion of keys 0..15
    keys_q.delete();
    core_q.delete();
    pulse_start();
    @(negedge clk);
    check("first_dispatch", {core_start, core_key[KW-1:0]}, {4'b0001, 24'd0});
    wait_end(300);
    check("ex_exhausted", 64'(exhausted), 64'd1);
    check("ex_found", 64'(found), 64'd0);
    check("ex_busy", 64'(busy), 64'd0);
    check("ex_count", 64'(keys_q.size()), 64'd16);
    check_order("ex_order");
`ifdef KEY_SEARCH_PROGRESS_EN
    check("ex_keys_tried", 64'(keys_tried), 64'd16);
`endif

    // Hit on key 9
    keys_q.delete();
    abort_cnt = 0;
    late_starts = 0;
    hit_a = 9;
    pulse_start();
    wait_end(300);
    repeat (5) @(negedge clk);
    check("hit_found", 64'(found), 64'd1);
    check("hit_key", 64'(found_key), 64'd9);
    check("hit_exhausted", 64'(exhausted), 64'd0);
    check("hit_aborts", 64'(abort_cnt), 64'd1);
    check("hit_late_starts", 64'(late_starts), 64'd0);
    check_order("hit_order");

    // Simultaneous hits on cores 1 and 2 (keys 5 and 6)
    keys_q.delete();
    abort_cnt = 0;
    hit_a = 5;
    hit_b = 6;
    slow_key = 5;
    pulse_start();
    wait_end(300);
    repeat (3) @(negedge clk);
    check("dual_key", 64'(found_key), 64'd5);
    check("dual_aborts", 64'(abort_cnt), 64'd1);

    // start during RUN is ignored
    hit_a = -1;
    hit_b = -1;
    slow_key = -1;
    keys_q.delete();
    pulse_start();
    wait_keys(6, 100);
    pulse_start();
    wait_end(300);
    check("run_start_count", 64'(keys_q.size()), 64'd16);
    check_order("run_start_order");
    check("run_start_exhausted", 64'(exhausted), 64'd1);

    // start in EXHAUSTED restarts from key 0
    keys_q.delete();
    pulse_start();
    check("restart_busy", {busy, exhausted}, 64'b10);
    wait_keys(1, 20);
    k = (keys_q.size() > 0) ? keys_q[0] : -1;
    check("restart_first_key", 64'(k), 64'd0);
    wait_end(300);

    // Reset mid-run at key 7
    keys_q.delete();
    core_q.delete();
    pulse_start();
    wait_keys(8, 100);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_outs", {core_start, busy, found, exhausted}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    keys_q.delete();
    core_q.delete();
    pulse_start();
    wait_keys(1, 20);
    k = (keys_q.size() > 0) ? keys_q[0] : -1;
    check("midreset_key", 64'(k), 64'd0);
    k = (core_q.size() > 0) ? core_q[0] : -1;
    check("midreset_core", 64'(k), 64'd0);
    check("midreset_flags", {found, exhausted}, 64'd0);
    wait_end(300);
    check("midreset_count", 64'(keys_q.size()), 64'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
